// File: rtl/tx_arb_pkg.sv
// ============================================================================
// Module   : tx_arb_pkg
// Purpose  : Shared types, constants and helpers for the TX port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tx_arb_pkg;

  // Arbiter sequencing: wait for a request, stream one packet, enforce idle gap.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Width of the externally visible event counters.
  localparam int CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tx_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational rotating-priority picker. Returns the first
//            asserted request at or above ptr (wrapping), one-hot and index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int j;

  // Walk the requesters starting at ptr and keep the first hit.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = IDX_W'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tx_arbiter.sv
// ============================================================================
// Module   : tx_arbiter
// Purpose  : Packet-atomic round-robin arbiter sharing one TX port among
//            NUM_REQ sources. A granted source owns the port until its eod;
//            a fixed idle gap follows every packet. Output is registered.
// Options  : TX_ARB_WATCHDOG_EN - force-terminate packets that stay BUSY
//            for TIMEOUT_CYCLES without an eod.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATA_W         = 64,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  output logic [NUM_REQ-1:0]        grant,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  input  logic [NUM_REQ-1:0]        in_valid,
  input  logic [NUM_REQ-1:0]        in_eod,
  input  logic                      tx_afull,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_valid,
  output logic                      tx_eod,
  output logic [CNT_W-1:0]          drop_count,
  output logic [CNT_W-1:0]          timeout_count
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One counter serves both the GAP countdown and the BUSY watchdog.
  localparam int CYC_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam logic [CYC_W-1:0] GAP_LOAD = CYC_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t             state, state_nx;
  logic [IDX_W-1:0]   ptr, ptr_nx;
  logic [IDX_W-1:0]   sel, sel_nx;
  logic [NUM_REQ-1:0] grant_nx;
  logic [CYC_W-1:0]   cyc, cyc_nx;
  logic [DATA_W-1:0]  tx_data_nx;
  logic               tx_valid_nx;
  logic               tx_eod_nx;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic [DATA_W-1:0]  sel_data;
  logic               sel_valid;
  logic               sel_eod;
  logic               timeout_hit;
  logic               drop_hit;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign sel_data  = in_data[int'(sel)*DATA_W +: DATA_W];
  assign sel_valid = in_valid[sel];
  assign sel_eod   = in_eod[sel];

  // A beat is lost whenever a source presents data without holding the grant.
  assign drop_hit  = |(in_valid & ~grant);

`ifdef TX_ARB_WATCHDOG_EN
  // Packet has been BUSY for TIMEOUT_CYCLES cycles and still shows no eod.
  assign timeout_hit = (state == BUSY) && !(sel_valid && sel_eod) &&
                       (cyc == CYC_W'(TIMEOUT_CYCLES - 1));

  // Count forced packet terminations.
  always_ff @(posedge clk) begin
    if (rst)              timeout_count <= '0;
    else if (timeout_hit) timeout_count <= sat_inc(timeout_count);
  end
`else
  assign timeout_hit   = 1'b0;
  assign timeout_count = '0;
`endif

  // Next-state, grant and registered-output selection.
  always_comb begin
    state_nx    = state;
    grant_nx    = grant;
    sel_nx      = sel;
    ptr_nx      = ptr;
    cyc_nx      = cyc;
    tx_valid_nx = 1'b0;
    tx_eod_nx   = 1'b0;
    tx_data_nx  = '0;
    case (state)
      IDLE: begin
        cyc_nx = '0;
        if (pick_any && !tx_afull) begin
          grant_nx = pick_onehot;
          sel_nx   = pick_idx;
          ptr_nx   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
          state_nx = BUSY;
        end
      end
      BUSY: begin
        tx_valid_nx = sel_valid;
        tx_eod_nx   = sel_valid & sel_eod;
        tx_data_nx  = sel_valid ? sel_data : '0;
`ifdef TX_ARB_WATCHDOG_EN
        cyc_nx      = cyc + CYC_W'(1);
`endif
        if (timeout_hit) begin
          tx_valid_nx = 1'b1;
          tx_eod_nx   = 1'b1;
          tx_data_nx  = '0;
        end
        if ((sel_valid && sel_eod) || timeout_hit) begin
          grant_nx = '0;
          cyc_nx   = GAP_LOAD;
          state_nx = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (cyc == '0) state_nx = IDLE;
        else           cyc_nx   = cyc - CYC_W'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, grant and TX output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= '0;
      ptr      <= '0;
      cyc      <= '0;
      tx_valid <= 1'b0;
      tx_eod   <= 1'b0;
      tx_data  <= '0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      sel      <= sel_nx;
      ptr      <= ptr_nx;
      cyc      <= cyc_nx;
      tx_valid <= tx_valid_nx;
      tx_eod   <= tx_eod_nx;
      tx_data  <= tx_data_nx;
    end
  end

  // Saturating count of cycles with at least one discarded beat.
  always_ff @(posedge clk) begin
    if (rst)           drop_count <= '0;
    else if (drop_hit) drop_count <= sat_inc(drop_count);
  end

endmodule

`default_nettype wire

// File: tb/tb_tx_arbiter.sv
// ============================================================================
// Module   : tb_tx_arbiter
// Purpose  : Self-checking bench for tx_arbiter: table of packets plus
//            hand-written afull, reset and watchdog sequences.
// Options  : TX_ARB_WATCHDOG_EN selects the forced-eod expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tx_arbiter;

  localparam int N  = 2;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_eod;
  logic            tx_afull;
  logic [DW-1:0]   tx_data;
  logic            tx_valid;
  logic            tx_eod;
  logic [15:0]     drop_count;
  logic [15:0]     timeout_count;

  tx_arbiter #(
    .NUM_REQ        (N),
    .DATA_W         (DW),
    .GAP_CYCLES     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .grant         (grant),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_eod        (in_eod),
    .tx_afull      (tx_afull),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_eod        (tx_eod),
    .drop_count    (drop_count),
    .timeout_count (timeout_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic [63:0] data;
    logic        eod;
    int          due;
  } beat_t;

  beat_t sb[$];

  typedef struct {
    logic [1:0] req;
    int         src;
    logic [1:0] exp_grant;
    int         exp_wait;
    int         len;
    bit         afull_mid;
    int         drop_n;
  } pkt_t;

  pkt_t tbl[7];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Compare every TX beat with the oldest expected beat, including its cycle.
  always @(negedge clk) begin
    beat_t e;
    if (tx_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("tx_valid_no_pending", {95'b0, tx_valid}, 96'd0);
      end else begin
        e = sb.pop_front();
        check("beat", {cyc_cnt[30:0], tx_eod, tx_data}, {e.due[30:0], e.eod, e.data});
      end
    end else begin
      check("idle_out", {31'b0, tx_eod, tx_data}, 96'd0);
    end
  end

  task automatic wait_grant(input logic [1:0] exp_g, input int exp_wait, input string name);
    int n;
    n = 0;
    while (grant == '0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_wait"}, n, exp_wait);
    check({name, "_grant"}, {94'b0, grant}, {94'b0, exp_g});
  endtask

  task automatic send_words(input int src, input int len, input bit afull_mid,
                            input int drop_n, input bit eod_last);
    logic [63:0] w;
    beat_t       e;
    for (int i = 0; i < len; i++) begin
      w        = {$urandom, $urandom};
      in_valid = '0;
      in_eod   = '0;
      in_data  = '0;
      in_valid[src]           = 1'b1;
      in_data[src*DW +: DW]   = w;
      in_eod[src]             = eod_last && (i == len - 1);
      if (i < drop_n) begin
        in_valid[1-src]         = 1'b1;
        in_data[(1-src)*DW +: DW] = 64'hDEAD_BEEF_0BAD_F00D;
      end
      tx_afull = afull_mid;
      e.data = w;
      e.eod  = in_eod[src];
      e.due  = cyc_cnt + 1;
      sb.push_back(e);
      @(posedge clk); #1;
    end
    in_valid = '0;
    in_eod   = '0;
    in_data  = '0;
    tx_afull = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d0;
    bit          held;
    beat_t       e;

    tbl[0] = '{req:2'b01, src:0, exp_grant:2'b01, exp_wait:1, len:8, afull_mid:0, drop_n:0};
    tbl[1] = '{req:2'b11, src:1, exp_grant:2'b10, exp_wait:5, len:4, afull_mid:0, drop_n:0};
    tbl[2] = '{req:2'b11, src:0, exp_grant:2'b01, exp_wait:5, len:6, afull_mid:0, drop_n:5};
    tbl[3] = '{req:2'b11, src:1, exp_grant:2'b10, exp_wait:5, len:1, afull_mid:1, drop_n:0};
    tbl[4] = '{req:2'b11, src:0, exp_grant:2'b01, exp_wait:5, len:5, afull_mid:1, drop_n:0};
    tbl[5] = '{req:2'b10, src:1, exp_grant:2'b10, exp_wait:5, len:2, afull_mid:0, drop_n:0};
    tbl[6] = '{req:2'b10, src:1, exp_grant:2'b10, exp_wait:5, len:3, afull_mid:0, drop_n:0};

    rst = 1'b1; req = '0; in_data = '0; in_valid = '0; in_eod = '0; tx_afull = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", {94'b0, grant}, 96'd0);
    check("rst_tx", {31'b0, tx_valid, tx_eod, tx_data}, 96'd0);
    check("rst_counts", {64'b0, drop_count, timeout_count}, 96'd0);
    rst = 1'b0;

    // Packet table: arbitration order, gap spacing, drops, afull ignored in BUSY.
    for (int t = 0; t < 7; t++) begin
      req = tbl[t].req;
      wait_grant(tbl[t].exp_grant, tbl[t].exp_wait, "arb");
      d0 = drop_count;
      send_words(tbl[t].src, tbl[t].len, tbl[t].afull_mid, tbl[t].drop_n, 1'b1);
      check("drop_delta", drop_count, d0 + 16'(tbl[t].drop_n));
      check("grant_release", {94'b0, grant}, 96'd0);
    end
    req = '0;

    // afull blocks a new grant; release gives grant on the next cycle.
    tx_afull = 1'b1;
    req      = 2'b01;
    repeat (10) @(posedge clk);
    #1;
    check("afull_block", {94'b0, grant}, 96'd0);
    tx_afull = 1'b0;
    wait_grant(2'b01, 1, "afull_rel");

    // Reset on the third word aborts the packet without an eod.
    send_words(0, 2, 1'b0, 0, 1'b0);
    in_valid[0]        = 1'b1;
    in_data[0 +: DW]   = 64'h3333_3333_3333_3333;
    rst                = 1'b1;
    @(posedge clk); #1;
    check("midrst_grant", {94'b0, grant}, 96'd0);
    check("midrst_tx", {31'b0, tx_valid, tx_eod, tx_data}, 96'd0);
    check("midrst_drop", drop_count, 96'd0);
    in_valid = '0;
    in_data  = '0;
    rst      = 1'b0;
    req      = 2'b10;
    wait_grant(2'b10, 1, "post_rst");
    req = '0;

`ifdef TX_ARB_WATCHDOG_EN
    // No eod: 15 real beats, then a forced zero-data eod beat in the 16th BUSY cycle.
    send_words(1, 15, 1'b0, 0, 1'b0);
    in_valid[1]       = 1'b1;
    in_data[DW +: DW] = 64'h5555_AAAA_5555_AAAA;
    e.data = '0;
    e.eod  = 1'b1;
    e.due  = cyc_cnt + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = '0;
    in_data  = '0;
    check("wd_grant_release", {94'b0, grant}, 96'd0);
    check("wd_timeout_count", timeout_count, 96'd1);
`else
    // No eod: grant must be held indefinitely.
    send_words(1, 16, 1'b0, 0, 1'b0);
    held = 1'b1;
    for (int i = 0; i < 110; i++) begin
      @(posedge clk); #1;
      if (grant !== 2'b10) held = 1'b0;
    end
    check("grant_held", {95'b0, held}, 96'd1);
    check("no_wd_timeout_count", timeout_count, 96'd0);
    send_words(1, 1, 1'b0, 0, 1'b1);
    check("late_eod_release", {94'b0, grant}, 96'd0);
`endif

    repeat (12) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 96'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
